// File: rtl/sap1_pkg.sv
// Shared types and default timing constants for the SAP-1 front-end clock control.
package sap1_pkg;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2
    } sap_ctrl_state_t;

    localparam int unsigned SAP_DEBOUNCE_CYCLES = 50000;
    localparam int unsigned SAP_AUTO_DIV        = 5000;

endpackage

// File: rtl/sap1_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for one panel input.
module sap1_debounce #(
    parameter int unsigned CYCLES  = 4,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o,
    output logic level_d_o
);

    localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic          s1_q, s2_q;
    logic          lvl_q, lvl_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q  <= RST_VAL;
            s2_q  <= RST_VAL;
            lvl_q <= RST_VAL;
            cnt_q <= '0;
        end else begin
            s1_q  <= raw_i;
            s2_q  <= s1_q;
            lvl_q <= lvl_d;
            cnt_q <= cnt_d;
        end
    end

    // The CYCLES-th consecutive differing sample flips the level.
    always_comb begin
        lvl_d = lvl_q;
        cnt_d = '0;
        if (s2_q != lvl_q) begin
            if (cnt_q == CW'(CYCLES - 1)) begin
                lvl_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign level_o   = lvl_q;
    assign level_d_o = lvl_d;

endmodule

// File: rtl/sap1_clock_ctrl.sv
// SAP-1 front end: debounced panel inputs, run/clear/halt FSM and step enable.
module sap1_clock_ctrl
    import sap1_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = SAP_DEBOUNCE_CYCLES,
    parameter int unsigned AUTO_DIV        = SAP_AUTO_DIV
) (
    input  logic sap_base_clock,
    input  logic sap_reset_n,
    input  logic sap_CleanStart_pb,
    input  logic sap_ManualAuto_sw,
    input  logic sap_SingleStep_pb,
    input  logic core_hlt,
    output logic cpu_clk_en,
    output logic cpu_clr,
    output logic cpu_running,
    output logic mode_auto
);

    localparam int unsigned DW = $clog2(AUTO_DIV);

    logic clr_lvl_q, clr_lvl_d;
    logic mode_lvl_q, mode_lvl_d;
    logic step_lvl_q, step_lvl_d;
    logic unused_lvl;

    sap1_debounce #(.CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b0)) u_db_clr (
        .clk_i     (sap_base_clock),
        .rst_ni    (sap_reset_n),
        .raw_i     (sap_CleanStart_pb),
        .level_o   (clr_lvl_q),
        .level_d_o (clr_lvl_d)
    );

    sap1_debounce #(.CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b0)) u_db_mode (
        .clk_i     (sap_base_clock),
        .rst_ni    (sap_reset_n),
        .raw_i     (sap_ManualAuto_sw),
        .level_o   (mode_lvl_q),
        .level_d_o (mode_lvl_d)
    );

    sap1_debounce #(.CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b0)) u_db_step (
        .clk_i     (sap_base_clock),
        .rst_ni    (sap_reset_n),
        .raw_i     (sap_SingleStep_pb),
        .level_o   (step_lvl_q),
        .level_d_o (step_lvl_d)
    );

    assign unused_lvl = clr_lvl_q ^ step_lvl_d;

    sap_ctrl_state_t state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic            step_prev_q;
    logic            en_q, en_d;
    logic            clr_q, run_q;
    logic            run_now, mode_tgl, div_wrap, step_rise;

    always_ff @(posedge sap_base_clock or negedge sap_reset_n) begin
        if (!sap_reset_n) begin
            state_q     <= S_CLEAR;
            div_q       <= '0;
            step_prev_q <= 1'b0;
            en_q        <= 1'b0;
            clr_q       <= 1'b1;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            step_prev_q <= step_lvl_q;
            en_q        <= en_d;
            clr_q       <= (state_d == S_CLEAR);
            run_q       <= (state_d == S_RUN);
        end
    end

    // FSM follows the debounced clear/start level as it updates this edge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_CLEAR: if (clr_lvl_d) state_d = S_RUN;
            S_RUN: begin
                if (!clr_lvl_d)    state_d = S_CLEAR;
                else if (core_hlt) state_d = S_HALT;
            end
            S_HALT:  if (!clr_lvl_d) state_d = S_CLEAR;
            default: state_d = S_CLEAR;
        endcase
    end

    assign run_now   = (state_q == S_RUN) && (state_d == S_RUN);
    assign mode_tgl  = mode_lvl_d ^ mode_lvl_q;
    assign div_wrap  = (div_q == DW'(AUTO_DIV - 1));
    assign step_rise = step_lvl_q & ~step_prev_q;

    always_comb begin
        div_d = '0;
        en_d  = 1'b0;
        if (run_now && !mode_tgl) begin
            if (mode_lvl_q) begin
                div_d = div_wrap ? '0 : div_q + 1'b1;
                en_d  = div_wrap;
            end else begin
                en_d  = step_rise;
            end
        end
    end

    assign cpu_clk_en  = en_q;
    assign cpu_clr     = clr_q;
    assign cpu_running = run_q;
    assign mode_auto   = mode_lvl_q;

endmodule

// File: tb/tb_sap1_clock_ctrl.sv
// Scoreboard bench: expected enable cycles are queued with stimulus and matched per cycle.
module tb_sap1_clock_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clean = 1'b0;
    logic mode = 1'b0;
    logic step = 1'b0;
    logic hlt = 1'b0;
    logic en, clr, running, mode_auto;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int pulse_cnt = 0;
    bit mon_on = 1'b0;
    bit exp_en;
    int sb[$];

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sap1_clock_ctrl #(.DEBOUNCE_CYCLES(4), .AUTO_DIV(8)) dut (
        .sap_base_clock    (clk),
        .sap_reset_n       (rst_n),
        .sap_CleanStart_pb (clean),
        .sap_ManualAuto_sw (mode),
        .sap_SingleStep_pb (step),
        .core_hlt          (hlt),
        .cpu_clk_en        (en),
        .cpu_clr           (clr),
        .cpu_running       (running),
        .mode_auto         (mode_auto)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0d want %0d at cyc %0d",
                     tag, got, exp, cyc);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic to_cyc(input int n);
        while (cyc < n) tick();
    endtask

    task automatic at_neg(input int n);
        to_cyc(n);
        @(negedge clk);
    endtask

    task automatic chk_outs(input string tag, input logic e_clr,
                            input logic e_run);
        chk({tag, "_clr"}, 32'(clr), 32'(e_clr));
        chk({tag, "_run"}, 32'(running), 32'(e_run));
    endtask

    always @(negedge clk) begin
        if (en === 1'b1) pulse_cnt++;
        if (mon_on) begin
            exp_en = (sb.size() > 0) && (sb[0] == cyc);
            chk("clk_en", 32'(en), 32'(exp_en));
            if (exp_en) void'(sb.pop_front());
        end
    end

    initial begin
        int n, q, r, x, u, base, s;

        repeat (8) begin
            tick();
            {clean, mode, step, hlt} = 4'($urandom);
            @(negedge clk);
            chk_outs("rst", 1'b1, 1'b0);
            chk("rst_en", 32'(en), 32'(0));
            chk("rst_mode", 32'(mode_auto), 32'(0));
        end
        {clean, mode, step, hlt} = 4'b0;
        rst_n = 1'b1;
        mon_on = 1'b1;
        ticks(3);

        n = cyc;
        clean = 1'b1;
        ticks(3);
        clean = 1'b0;
        repeat (12) begin
            @(negedge clk);
            chk_outs("glitch", 1'b1, 1'b0);
        end

        tick();
        n = cyc;
        mode = 1'b1;
        at_neg(n + 5);
        chk("mode_pre", 32'(mode_auto), 32'(0));
        at_neg(n + 6);
        chk("mode_auto", 32'(mode_auto), 32'(1));
        ticks(4);

        n = cyc;
        clean = 1'b1;
        sb.push_back(n + 14);
        sb.push_back(n + 22);
        sb.push_back(n + 30);
        at_neg(n + 5);
        chk_outs("start_pre", 1'b1, 1'b0);
        at_neg(n + 6);
        chk_outs("start", 1'b0, 1'b1);

        to_cyc(n + 37);
        hlt = 1'b1;
        tick();
        hlt = 1'b0;
        @(negedge clk);
        chk_outs("halt", 1'b0, 1'b0);
        ticks(20);
        @(negedge clk);
        chk_outs("halt_hold", 1'b0, 1'b0);

        tick();
        q = cyc;
        clean = 1'b0;
        at_neg(q + 5);
        chk_outs("clear_pre", 1'b0, 1'b0);
        at_neg(q + 6);
        chk_outs("clear", 1'b1, 1'b0);
        to_cyc(q + 10);
        r = cyc;
        clean = 1'b1;
        sb.push_back(r + 14);
        sb.push_back(r + 22);
        at_neg(r + 6);
        chk_outs("restart", 1'b0, 1'b1);

        to_cyc(r + 22);
        x = cyc;
        mode = 1'b0;
        at_neg(x + 5);
        chk("flip_pre", 32'(mode_auto), 32'(1));
        at_neg(x + 6);
        chk("flip", 32'(mode_auto), 32'(0));

        to_cyc(x + 12);
        base = pulse_cnt;
        for (int i = 0; i < 5; i++) begin
            s = cyc;
            step = 1'b1;
            sb.push_back(s + 7);
            ticks(10);
            step = 1'b0;
            ticks(10);
        end
        chk("man_pulses", 32'(pulse_cnt - base), 32'(5));

        u = cyc;
        mode = 1'b1;
        for (int k = 0; k < 16; k++) sb.push_back(u + 14 + 8 * k);
        at_neg(u + 6);
        chk("auto_again", 32'(mode_auto), 32'(1));
        to_cyc(u + 8);
        for (int i = 0; i < 5; i++) begin
            step = 1'b1;
            ticks(10);
            step = 1'b0;
            ticks(10);
        end

        to_cyc(u + 126);
        chk("pre_rst_en", 32'(en), 32'(1));
        mon_on = 1'b0;
        sb.delete();
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("async_rst", 1'b1, 1'b0);
        chk("async_rst_en", 32'(en), 32'(0));
        chk("async_rst_mode", 32'(mode_auto), 32'(0));
        {clean, mode, step, hlt} = 4'b0;
        ticks(3);
        @(negedge clk);
        rst_n = 1'b1;
        mon_on = 1'b1;
        ticks(12);
        @(negedge clk);
        chk_outs("post_rst", 1'b1, 1'b0);

        chk("sb_empty", 32'(sb.size()), 32'(0));
        mon_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
